// File: rtl/mod_div_rest_6b.sv
// mod_div_rest_6b: multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operation; otherwise operands are unsigned.
module mod_div_rest_6b #(
   parameter int W = 6
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         BUSY,
   output logic         DONE,
   output logic         DZ,
   output logic         OVF,
   output logic [1:0]   dbg_state
);
   // Handshake: START is taken only in IDLE; BUSY rises the next cycle and falls
   // as DONE pulses for one cycle, from which Q/R/DZ/OVF hold until the next DONE.
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_cap, quo, mag_a_in, q_fix, r_fix;
   logic [W:0]    p, p_sh, mag_b, mag_b_in;
   logic [W+1:0]  diff;
   logic          geq, dz_int, ovf_int, ovf_in;
   logic          load_op, step, finish;
`ifdef DIV_SIGNED_EN
   logic          sa, sb;
`endif

   // Operand magnitudes; |-2^(W-1)| wraps to 2^(W-1), which is right read as unsigned.
   always_comb begin
`ifdef DIV_SIGNED_EN
      mag_a_in = A[W-1] ? (~A + W'(1)) : A;
      mag_b_in = B[W-1] ? (~{B[W-1], B} + (W+1)'(1)) : {B[W-1], B};
      ovf_in   = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
`else
      mag_a_in = A;
      mag_b_in = {1'b0, B};
      ovf_in   = 1'b0;
`endif
   end

   // One restoring step: a set bit shifted out of P means P already exceeds |B|.
   always_comb begin
      p_sh = {p[W-1:0], quo[W-1]};
      diff = {1'b0, p_sh} + {1'b0, ~mag_b} + (W+2)'(1);
      geq  = p[W] | diff[W+1];
   end

   always_comb begin
      q_fix = quo;
      r_fix = p[W-1:0];
      if (dz_int) begin
         q_fix = '1;
         r_fix = a_cap;
      end
`ifdef DIV_SIGNED_EN
      else if (ovf_int) begin
         q_fix = {1'b1, {(W-1){1'b0}}};
         r_fix = '0;
      end else begin
         if (sa ^ sb) q_fix = ~quo + W'(1);
         if (sa)      r_fix = ~p[W-1:0] + W'(1);
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = CALC;
         CALC:    if (cnt == CW'(1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_op   = (state == IDLE) && START;
      step      = (state == CALC);
      finish    = (state == FIX);
      dbg_state = state;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         a_cap   <= '0;
         quo     <= '0;
         p       <= '0;
         mag_b   <= '0;
         dz_int  <= 1'b0;
         ovf_int <= 1'b0;
`ifdef DIV_SIGNED_EN
         sa      <= 1'b0;
         sb      <= 1'b0;
`endif
         Q       <= '0;
         R       <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         DZ      <= 1'b0;
         OVF     <= 1'b0;
      end else begin
         DONE <= finish;
         if (load_op) begin
            cnt     <= CW'(W);
            a_cap   <= A;
            quo     <= mag_a_in;
            p       <= '0;
            mag_b   <= mag_b_in;
            dz_int  <= (B == '0);
            ovf_int <= ovf_in;
`ifdef DIV_SIGNED_EN
            sa      <= A[W-1];
            sb      <= B[W-1];
`endif
            BUSY    <= 1'b1;
         end
         if (step) begin
            cnt <= cnt - CW'(1);
            p   <= geq ? diff[W:0] : p_sh;
            quo <= {quo[W-2:0], geq};
         end
         if (finish) begin
            Q    <= q_fix;
            R    <= r_fix;
            DZ   <= dz_int;
            OVF  <= ovf_int;
            BUSY <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mod_div_rest_6b.sv
// Directed bench for mod_div_rest_6b; expectations follow the DIV_SIGNED_EN build setting.
module tb_mod_div_rest_6b;
   localparam int W = 6;

   logic         CLK = 1'b0;
   logic         RST, START;
   logic [W-1:0] A, B, Q, R;
   logic         BUSY, DONE, DZ, OVF;
   logic [1:0]   dbg_state;
   int           n_assert = 0;
   int           n_fail = 0;
   int           lat;
   int           done_seen;

   mod_div_rest_6b #(.W(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DZ(DZ), .OVF(OVF),
      .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Signed-build value first, unsigned-build value second.
   function automatic logic [W-1:0] pk(input logic [W-1:0] s, input logic [W-1:0] u);
`ifdef DIV_SIGNED_EN
      return s;
`else
      return u;
`endif
   endfunction

   // Operands are scrambled right after acceptance; the result must ignore that.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      A = a;
      B = b;
      START = 1'b1;
      tick();
      START = 1'b0;
      A = W'($urandom_range(0, 63));
      B = W'($urandom_range(0, 63));
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (DONE) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic check_res(input string tag, input int n, input logic [W-1:0] q,
                            input logic [W-1:0] r, input logic dz, input logic ovf);
      chk({tag, "_lat"}, n, 7);
      chk({tag, "_q"}, Q, q);
      chk({tag, "_r"}, R, r);
      chk({tag, "_dz"}, DZ, dz);
      chk({tag, "_ovf"}, OVF, ovf);
      chk({tag, "_busy"}, BUSY, 1'b0);
   endtask

   task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input logic ovf);
      int n;
      start_op(a, b);
      chk({tag, "_busy_on"}, BUSY, 1'b1);
      wait_done(n);
      check_res(tag, n, q, r, dz, ovf);
      tick();
      chk({tag, "_done_pulse"}, DONE, 1'b0);
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      A = '0;
      B = '0;
      tick();
      tick();
      chk("rst_q", Q, 0);
      chk("rst_r", R, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_dz", DZ, 0);
      chk("rst_ovf", OVF, 0);
      chk("rst_state", dbg_state, 0);
      RST = 1'b0;
      tick();

      // 44 = -20, 61 = -3, 58 = -6, 62 = -2, 32 = -32, 63 = -1, 59 = -5, 57 = -7
      op("pp", 6'd20, 6'd3,  6'd6,             6'd2,             1'b0, 1'b0);
      op("np", 6'd44, 6'd3,  pk(6'd58, 6'd14), pk(6'd62, 6'd2),  1'b0, 1'b0);
      op("pn", 6'd20, 6'd61, pk(6'd58, 6'd0),  pk(6'd2, 6'd20),  1'b0, 1'b0);
      op("nn", 6'd44, 6'd61, pk(6'd6, 6'd0),   pk(6'd62, 6'd44), 1'b0, 1'b0);
      op("ovf", 6'd32, 6'd63, pk(6'd32, 6'd0), pk(6'd0, 6'd32),  1'b0, pk(6'd1, 6'd0) != 0);
      op("m32_1", 6'd32, 6'd1, 6'd32,          6'd0,             1'b0, 1'b0);
      op("eq31", 6'd31, 6'd31, 6'd1,           6'd0,             1'b0, 1'b0);
      op("zero", 6'd0, 6'd59,  6'd0,           6'd0,             1'b0, 1'b0);
      op("dz", 6'd57, 6'd0,    6'd63,          6'd57,            1'b1, 1'b0);

      // DZ survives START and is cleared only by the next completion
      start_op(6'd9, 6'd2);
      chk("sticky_dz", DZ, 1'b1);
      wait_done(lat);
      check_res("after_dz", lat, 6'd4, 6'd1, 1'b0, 1'b0);
      tick();

      op("u56", 6'd56, 6'd3, pk(6'd62, 6'd18), pk(6'd62, 6'd2), 1'b0, 1'b0);

      // START pulses while busy are dropped
      start_op(6'd9, 6'd2);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 2 || i == 4) begin
            A = 6'd20;
            B = 6'd3;
            START = 1'b1;
         end else begin
            START = 1'b0;
         end
         tick();
         if (DONE) begin
            lat = i;
            break;
         end
      end
      START = 1'b0;
      check_res("busy_ign", lat, 6'd4, 6'd1, 1'b0, 1'b0);
      tick();
      chk("busy_ign_idle", BUSY, 1'b0);

      // back-to-back: START in the DONE cycle is accepted, old result holds
      start_op(6'd20, 6'd3);
      wait_done(lat);
      check_res("b2b_first", lat, 6'd6, 6'd2, 1'b0, 1'b0);
      start_op(6'd44, 6'd3);
      chk("b2b_busy", BUSY, 1'b1);
      chk("b2b_done_low", DONE, 1'b0);
      chk("b2b_hold_q", Q, 6'd6);
      wait_done(lat);
      check_res("b2b_second", lat, pk(6'd58, 6'd14), pk(6'd62, 6'd2), 1'b0, 1'b0);
      tick();

      // reset in the middle of CALC abandons the operation
      start_op(6'd20, 6'd3);
      tick();
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("midrst_q", Q, 0);
      chk("midrst_r", R, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_state", dbg_state, 0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (DONE) done_seen++;
      end
      chk("midrst_no_done", done_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
